// File: rtl/spdif_bmc_encoder_pkg.sv
// Shared S/PDIF definitions: format codes, preamble patterns, channel-status codes
// and the encoder FSM state type.
package spdif_bmc_encoder_pkg;

    localparam logic [1:0] BIT_DEPTH_16  = 2'd0;
    localparam logic [1:0] BIT_DEPTH_24  = 2'd1;
    localparam logic [1:0] BIT_DEPTH_32  = 2'd2;
    localparam logic [1:0] BIT_DEPTH_DOP = 2'd3;

    localparam logic [2:0] SAMPLE_RATE_44K1  = 3'd0;
    localparam logic [2:0] SAMPLE_RATE_48K   = 3'd1;
    localparam logic [2:0] SAMPLE_RATE_88K2  = 3'd2;
    localparam logic [2:0] SAMPLE_RATE_96K   = 3'd3;
    localparam logic [2:0] SAMPLE_RATE_176K4 = 3'd4;
    localparam logic [2:0] SAMPLE_RATE_192K  = 3'd5;

    // Cell sequences for a line level of 0, first cell in bit 7.
    localparam logic [7:0] PREAMBLE_B = 8'b11101000;
    localparam logic [7:0] PREAMBLE_M = 8'b11100010;
    localparam logic [7:0] PREAMBLE_W = 8'b11100100;

    localparam int         BLOCK_FRAMES = 192;
    localparam logic [7:0] LAST_FRAME   = 8'(BLOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2
    } enc_state_e;

    // Channel-status codes; bit 3 is transmitted first (bit 24 / bit 32).
    function automatic logic [3:0] cs_fs_code(input logic [2:0] rate);
        case (rate)
            SAMPLE_RATE_48K:   return 4'b0100;
            SAMPLE_RATE_88K2:  return 4'b0001;
            SAMPLE_RATE_96K:   return 4'b0101;
            SAMPLE_RATE_176K4: return 4'b0011;
            SAMPLE_RATE_192K:  return 4'b0111;
            default:           return 4'b0000;
        endcase
    endfunction

    // 32-bit and DoP are carried as 24-bit words.
    function automatic logic [3:0] cs_wl_code(input logic [1:0] depth);
        return (depth == BIT_DEPTH_16) ? 4'b0100 : 4'b1101;
    endfunction

endpackage

// File: rtl/spdif_channel_status.sv
// Channel-status lookup: returns the C bit carried by a given frame of the block.
module spdif_channel_status
    import spdif_bmc_encoder_pkg::*;
(
    input  logic [7:0] frame_idx,
    input  logic [2:0] sample_rate,
    input  logic [1:0] bit_depth,
    output logic       cs_bit
);

    logic [3:0] fs_code;
    logic [3:0] wl_code;

    assign fs_code = cs_fs_code(sample_rate);
    assign wl_code = cs_wl_code(bit_depth);

    always_comb begin
        cs_bit = 1'b0;
        if (frame_idx == 8'd2) begin
            cs_bit = 1'b1;
        end else if (frame_idx[7:2] == 6'd6) begin
            cs_bit = fs_code[2'd3 - frame_idx[1:0]];
        end else if (frame_idx[7:2] == 6'd8) begin
            cs_bit = wl_code[2'd3 - frame_idx[1:0]];
        end
    end

endmodule

// File: rtl/spdif_bmc_encoder.sv
// S/PDIF subframe builder and biphase-mark line encoder, one half-bit cell per cell_en_i.
// Each subframe is 8 preamble cells followed by 28 BMC-coded bits (slots 4-31).
module spdif_bmc_encoder
    import spdif_bmc_encoder_pkg::*;
(
    input  logic        byte_clk_i,
    input  logic        reset_i,
    input  logic        cell_en_i,
    input  logic        enable_i,
    input  logic [1:0]  bit_depth_i,
    input  logic [2:0]  sample_rate_i,
    input  logic [23:0] sample_i,
    input  logic        sample_valid_i,
    output logic        sample_ready_o,
    output logic        spdif_o,
    output logic        active_o,
    output logic        underrun_o,
    output logic        block_start_o,
    output logic [1:0]  dbg_state
);

    // Handshake: a sample transfers on a rising edge where sample_valid_i and
    // sample_ready_o are both high; ready is high exactly while the buffer is empty.

    enc_state_e  state_q, state_d;
    logic [5:0]  cell_q, cell_d;
    logic        load_sf, sf_end, emit, cell_val;
    logic [7:0]  frame_q;
    logic        right_q;
    logic [6:0]  pre_q;
    logic [27:0] word_q;
    logic        buf_full_q;
    logic [23:0] buf_q;
    logic [1:0]  depth_q, eff_depth;
    logic [2:0]  rate_q, eff_rate;
    logic        spdif_q, underrun_q, block_start_q;
    logic        first_frame, cs_bit, v_bit, parity;
    logic [23:0] smp;
    logic [7:0]  pat, pat_lvl;
    logic [27:0] sub_word;

    always_ff @(posedge byte_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cell_q  <= 6'd0;
        end else begin
            state_q <= state_d;
            cell_q  <= cell_d;
        end
    end

    // load_sf marks the cell that starts a subframe (first preamble cell).
    always_comb begin
        state_d = state_q;
        cell_d  = cell_q;
        load_sf = 1'b0;
        sf_end  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cell_en_i && enable_i) begin
                    load_sf = 1'b1;
                    state_d = ST_PREAMBLE;
                    cell_d  = 6'd1;
                end
            end
            ST_PREAMBLE: begin
                if (cell_en_i) begin
                    load_sf = (cell_q == 6'd0);
                    if (cell_q == 6'd7) begin
                        state_d = ST_DATA;
                        cell_d  = 6'd0;
                    end else begin
                        cell_d = cell_q + 6'd1;
                    end
                end
            end
            ST_DATA: begin
                if (cell_en_i) begin
                    if (cell_q == 6'd55) begin
                        sf_end  = 1'b1;
                        cell_d  = 6'd0;
                        state_d = (right_q && !enable_i) ? ST_IDLE : ST_PREAMBLE;
                    end else begin
                        cell_d = cell_q + 6'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Format is latched only at the block start; that subframe already uses the new inputs.
    assign first_frame = (frame_q == 8'd0) && !right_q;
    assign eff_depth   = (load_sf && first_frame) ? bit_depth_i   : depth_q;
    assign eff_rate    = (load_sf && first_frame) ? sample_rate_i : rate_q;

    spdif_channel_status u_cs (
        .frame_idx   (frame_q),
        .sample_rate (eff_rate),
        .bit_depth   (eff_depth),
        .cs_bit      (cs_bit)
    );

    always_comb begin
        smp = buf_full_q ? buf_q : 24'd0;
        if (eff_depth == BIT_DEPTH_16) begin
            smp[7:0] = 8'd0;
        end
    end

    assign v_bit    = !buf_full_q;
    assign parity   = ^{cs_bit, 1'b0, v_bit, smp};
    assign sub_word = {parity, cs_bit, 1'b0, v_bit, smp};
    assign pat      = right_q ? PREAMBLE_W : ((frame_q == 8'd0) ? PREAMBLE_B : PREAMBLE_M);
    assign pat_lvl  = pat ^ {8{spdif_q}};
    assign emit     = cell_en_i && ((state_q != ST_IDLE) || load_sf);

    // Even cell of a bit always toggles; odd cell toggles again for a 1.
    always_comb begin
        cell_val = spdif_q;
        if (load_sf) begin
            cell_val = pat_lvl[7];
        end else if (state_q == ST_PREAMBLE) begin
            cell_val = pre_q[6];
        end else if (state_q == ST_DATA) begin
            cell_val = cell_q[0] ? (spdif_q ^ word_q[0]) : !spdif_q;
        end
    end

    always_ff @(posedge byte_clk_i or posedge reset_i) begin
        if (reset_i) begin
            spdif_q       <= 1'b0;
            underrun_q    <= 1'b0;
            block_start_q <= 1'b0;
            pre_q         <= 7'd0;
            word_q        <= 28'd0;
            frame_q       <= 8'd0;
            right_q       <= 1'b0;
            depth_q       <= BIT_DEPTH_16;
            rate_q        <= SAMPLE_RATE_44K1;
            buf_full_q    <= 1'b0;
            buf_q         <= 24'd0;
        end else begin
            underrun_q    <= 1'b0;
            block_start_q <= 1'b0;
            if (emit) begin
                spdif_q <= cell_val;
            end
            if (load_sf) begin
                pre_q         <= pat_lvl[6:0];
                word_q        <= sub_word;
                underrun_q    <= !buf_full_q;
                block_start_q <= first_frame;
                if (first_frame) begin
                    depth_q <= bit_depth_i;
                    rate_q  <= sample_rate_i;
                end
            end else if (cell_en_i && (state_q == ST_PREAMBLE)) begin
                pre_q <= {pre_q[5:0], 1'b0};
            end else if (cell_en_i && (state_q == ST_DATA) && cell_q[0]) begin
                word_q <= {1'b0, word_q[27:1]};
            end
            if (sf_end) begin
                if (right_q) begin
                    right_q <= 1'b0;
                    frame_q <= ((state_d == ST_IDLE) || (frame_q == LAST_FRAME)) ? 8'd0 : frame_q + 8'd1;
                end else begin
                    right_q <= 1'b1;
                end
            end
            if (load_sf) begin
                buf_full_q <= 1'b0;
            end
            if (sample_valid_i && !buf_full_q) begin
                buf_full_q <= 1'b1;
                buf_q      <= sample_i;
            end
        end
    end

    assign sample_ready_o = !buf_full_q;
    assign spdif_o        = spdif_q;
    assign active_o       = (state_q != ST_IDLE);
    assign underrun_o     = underrun_q;
    assign block_start_o  = block_start_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_spdif_bmc_encoder.sv
// Directed bench for spdif_bmc_encoder: logs every emitted cell and decodes subframes
// against hand-derived preambles, words and channel-status codes.
module tb_spdif_bmc_encoder;
    import spdif_bmc_encoder_pkg::*;

    logic        byte_clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cell_en_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [1:0]  bit_depth_i = BIT_DEPTH_24;
    logic [2:0]  sample_rate_i = SAMPLE_RATE_48K;
    logic [23:0] sample_i = 24'd0;
    logic        sample_valid_i = 1'b0;
    logic        sample_ready_o, spdif_o, active_o, underrun_o, block_start_o;
    logic [1:0]  dbg_state;

    spdif_bmc_encoder dut (
        .byte_clk_i     (byte_clk_i),
        .reset_i        (reset_i),
        .cell_en_i      (cell_en_i),
        .enable_i       (enable_i),
        .bit_depth_i    (bit_depth_i),
        .sample_rate_i  (sample_rate_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .spdif_o        (spdif_o),
        .active_o       (active_o),
        .underrun_o     (underrun_o),
        .block_start_o  (block_start_o),
        .dbg_state      (dbg_state)
    );

    always #5 byte_clk_i = ~byte_clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cell_period = 4;
    bit          cell_run = 1'b0;
    int          gap = 0;
    int          ur_pulses = 0;
    logic        cells[$];
    logic        urs[$];
    logic        bss[$];
    logic [23:0] exp_q[$];
    int          seq = 0;
    bit          pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // cell strobe generator
    initial forever begin
        @(negedge byte_clk_i);
        if (cell_run && gap == 0) begin
            cell_en_i = 1'b1;
            gap = cell_period - 1;
        end else begin
            cell_en_i = 1'b0;
            if (gap > 0) gap--;
        end
    end

    // cell monitor: one entry per emitted cell
    initial begin
        logic act_b, ce;
        forever begin
            @(negedge byte_clk_i);
            act_b = active_o;
            @(posedge byte_clk_i);
            ce = cell_en_i;
            #1;
            if (underrun_o) ur_pulses++;
            if (ce && (act_b || active_o)) begin
                cells.push_back(spdif_o);
                urs.push_back(underrun_o);
                bss.push_back(block_start_o);
            end
        end
    end

    function automatic logic [7:0] pre_at(int k);
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[7-i] = cells[k+i];
        return p;
    endfunction

    function automatic logic [27:0] word_at(int k);
        logic [27:0] w;
        for (int i = 0; i < 28; i++) w[i] = cells[k+8+2*i] ^ cells[k+9+2*i];
        return w;
    endfunction

    function automatic int bmc_errs(int k);
        int e = 0;
        for (int i = 0; i < 28; i++) if (cells[k+8+2*i] == cells[k+7+2*i]) e++;
        return e;
    endfunction

    function automatic logic lvl_before(int k);
        return (k == 0) ? 1'b0 : cells[k-1];
    endfunction

    task automatic do_reset();
        enable_i = 1'b0;
        sample_valid_i = 1'b0;
        reset_i = 1'b1;
        repeat (3) @(negedge byte_clk_i);
        reset_i = 1'b0;
        @(negedge byte_clk_i);
        cells.delete(); urs.delete(); bss.delete();
    endtask

    task automatic wait_cells(input int n, input int budget);
        int t = 0;
        while (cells.size() < n && t < budget) begin
            @(negedge byte_clk_i);
            t++;
        end
        if (t >= budget) check("wait_cells_timeout", cells.size(), n);
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (active_o && t < budget) begin
            @(negedge byte_clk_i);
            t++;
        end
        check("idle_reached", active_o, 1'b0);
    endtask

    task automatic push_sample(input logic [23:0] d);
        int t = 0;
        sample_i = d;
        sample_valid_i = 1'b1;
        while (!sample_ready_o && t < 400) begin
            @(negedge byte_clk_i);
            t++;
        end
        check("push_ready_seen", sample_ready_o, 1'b1);
        @(posedge byte_clk_i);
        #1;
        check("ready_drop", sample_ready_o, 1'b0);
        @(negedge byte_clk_i);
        sample_valid_i = 1'b0;
    endtask

    task automatic stream_step();
        sample_valid_i = 1'b1;
        if (pending) begin
            seq++;
            sample_i = {seq[15:0], seq[7:0] ^ 8'h5A};
            pending = 1'b0;
        end
        if (sample_ready_o) begin
            exp_q.push_back(sample_i);
            pending = 1'b1;
        end
    endtask

    initial begin
        logic        lvl;
        int          t, errs, bs_errs;
        logic [27:0] w;
        logic [23:0] e;
        logic [7:0]  pat;
        logic        last_c;
        logic [191:0] cs0, cs1;

        // reset state
        repeat (3) @(negedge byte_clk_i);
        #1;
        check("rst_spdif", spdif_o, 1'b0);
        check("rst_ready", sample_ready_o, 1'b1);
        check("rst_active", active_o, 1'b0);
        check("rst_underrun", underrun_o, 1'b0);
        check("rst_block_start", block_start_o, 1'b0);
        @(negedge byte_clk_i);
        reset_i = 1'b0;
        @(negedge byte_clk_i);

        // underrun stream, enable dropped mid-left
        cell_run = 1'b1;
        cell_period = 4;
        enable_i = 1'b1;
        wait_cells(20, 400);
        enable_i = 1'b0;
        wait_idle(2000);
        check("t2_cells", cells.size(), 128);
        if (cells.size() >= 128) begin
            check("t2_pre_b", pre_at(0), 8'b11101000);
            check("t2_word_l", word_at(0), {1'b1, 1'b0, 1'b0, 1'b1, 24'h0});
            check("t2_ur_l", urs[0], 1'b1);
            check("t2_ur_r", urs[64], 1'b1);
            check("t2_bs_l", bss[0], 1'b1);
            check("t2_bs_r", bss[64], 1'b0);
            check("t2_pre_w", pre_at(64), 8'b11100100 ^ {8{cells[63]}});
            check("t2_word_r", word_at(64), {1'b1, 1'b0, 1'b0, 1'b1, 24'h0});
            check("t2_bmc", bmc_errs(0) + bmc_errs(64), 0);
        end
        lvl = spdif_o;
        repeat (40) @(negedge byte_clk_i);
        check("t2_hold_level", spdif_o, lvl);
        check("t2_hold_idle", active_o, 1'b0);

        // 24-bit samples 0x000001 / 0xFFFFFF
        do_reset();
        push_sample(24'h000001);
        enable_i = 1'b1;
        push_sample(24'hFFFFFF);
        enable_i = 1'b0;
        wait_idle(2000);
        check("t3_cells", cells.size(), 128);
        if (cells.size() >= 128) begin
            check("t3_word_l", word_at(0), {1'b1, 3'b000, 24'h000001});
            check("t3_word_r", word_at(64), {4'b0000, 24'hFFFFFF});
            check("t3_ur_l", urs[0], 1'b0);
            check("t3_ur_r", urs[64], 1'b0);
            check("t3_pre_w", pre_at(64), 8'b11100100 ^ {8{cells[63]}});
        end

        // 400 frames at 48k/16-bit, valid held high, depth switched to 32 mid-block
        do_reset();
        bit_depth_i = BIT_DEPTH_16;
        sample_rate_i = SAMPLE_RATE_48K;
        cell_period = 1;
        ur_pulses = 0;
        exp_q.delete();
        seq = 0;
        pending = 1'b0;
        sample_i = {16'h0000, 8'h5A};
        repeat (3) begin
            @(negedge byte_clk_i);
            stream_step();
        end
        enable_i = 1'b1;
        t = 0;
        while (t < 60000 && !(cells.size() >= 51100 && !active_o)) begin
            @(negedge byte_clk_i);
            stream_step();
            if (cells.size() >= 1280) bit_depth_i = BIT_DEPTH_32;
            if (cells.size() >= 51170) enable_i = 1'b0;
            t++;
        end
        sample_valid_i = 1'b0;
        check("t4_cells", cells.size(), 51200);
        check("t4_no_underrun", ur_pulses, 0);
        errs = 0;
        bs_errs = 0;
        cs0 = '0;
        cs1 = '0;
        last_c = 1'b0;
        if (cells.size() >= 51200) begin
            for (int s = 0; s < 800; s++) begin
                int k, fr;
                k = 64 * s;
                fr = s / 2;
                w = word_at(k);
                if (exp_q.size() == 0) begin
                    errs++;
                end else begin
                    e = exp_q.pop_front();
                    if (fr < 192) e[7:0] = 8'h00;
                    if (w[23:0] !== e) errs++;
                end
                if (w[24] !== 1'b0) errs++;
                if ((^w) !== 1'b0) errs++;
                errs += bmc_errs(k);
                pat = (s % 2 == 1) ? 8'b11100100 : ((fr % 192 == 0) ? 8'b11101000 : 8'b11100010);
                if (pre_at(k) !== (pat ^ {8{lvl_before(k)}})) errs++;
                if (bss[k] !== ((s % 384) == 0)) bs_errs++;
                if (s % 2 == 0) begin
                    last_c = w[26];
                    if (fr < 192) cs0[fr] = w[26];
                    else if (fr < 384) cs1[fr-192] = w[26];
                end else if (w[26] !== last_c) begin
                    errs++;
                end
            end
        end
        check("t4_subframe_errs", errs, 0);
        check("t4_block_start_errs", bs_errs, 0);
        check("t4_cs_fs", {cs0[24], cs0[25], cs0[26], cs0[27]}, 4'b0100);
        check("t4_cs_wl16", {cs0[32], cs0[33], cs0[34], cs0[35]}, 4'b0100);
        check("t4_cs_ones", $countones(cs0), 3);
        check("t4_cs1_fs", {cs1[24], cs1[25], cs1[26], cs1[27]}, 4'b0100);
        check("t4_cs1_wl32", {cs1[32], cs1[33], cs1[34], cs1[35]}, 4'b1101);
        check("t4_leftover", exp_q.size(), 1);

        // asynchronous reset in the middle of data cells
        do_reset();
        bit_depth_i = BIT_DEPTH_24;
        cell_period = 4;
        enable_i = 1'b1;
        wait_cells(20, 400);
        t = 0;
        while (spdif_o !== 1'b1 && t < 200) begin
            @(negedge byte_clk_i);
            t++;
        end
        check("t6_pre_level", spdif_o, 1'b1);
        reset_i = 1'b1;
        #1;
        check("t6_rst_spdif", spdif_o, 1'b0);
        check("t6_rst_active", active_o, 1'b0);
        check("t6_rst_ready", sample_ready_o, 1'b1);
        enable_i = 1'b0;
        repeat (2) @(negedge byte_clk_i);
        reset_i = 1'b0;
        cell_run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spdif_bmc_encoder.md
SPDIF_BMC_ENCODER -- requirements
Module: spdif_bmc_encoder

Interface
REQ-001 SHALL have port reset_i  in  1  asynchronous active-high reset.
REQ-002 SHALL have port byte_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port cell_en_i  in  1  one-cycle strobe at 128 x fs; one BMC half-bit cell per strobe.
REQ-004 SHALL have port enable_i  in  1  level; start/stop streaming.
REQ-005 SHALL have port bit_depth_i  in  2  shared BIT_DEPTH_* encoding (16/24 only).
REQ-006 SHALL have port sample_rate_i  in  3  shared SAMPLE_RATE_* encoding.
REQ-007 SHALL have port sample_i  in  24  audio sample, MSB-aligned; 16-bit uses [23:8], [7:0]=0.
REQ-008 SHALL have ports sample_valid_i in 1 / sample_ready_o out 1: valid/ready handshake; transfer when both high.
REQ-009 SHALL have port spdif_o  out  1  registered BMC line output.
REQ-010 SHALL have ports active_o, underrun_o, block_start_o  out  1 each: streaming flag; one-cycle underrun pulse; one-cycle pulse at each B preamble start.

Function
REQ-011 SHALL hold one-entry sample buffer; sample_ready_o = buffer empty; simultaneous load and consume SHALL keep buffer full with new data.
REQ-012 SHALL run FSM IDLE -> PREAMBLE (8 cells) -> DATA (56 cells, slots 4-31) -> PREAMBLE ...; state advances only on cell_en_i.
REQ-013 IDLE -> PREAMBLE on first cell_en_i with enable_i=1; frame counter=0, channel=left.
REQ-014 At PREAMBLE entry SHALL move buffer into shift register; buffer empty -> send zero sample, V=1, pulse underrun_o.
REQ-015 Preamble: left frame 0 = B 11101000, other left = M 11100010, right = W 11100100, for line level 0; bitwise inverted when line level is 1.
REQ-016 Slots 4-27 SHALL carry sample_i[0..23] LSB first; slot 28 V (0 unless underrun), 29 U=0, 30 C=channel-status bit[frame], 31 P = even parity over slots 4-30.
REQ-017 BMC: line toggles at every bit start; additional toggle at mid-bit for 1.
REQ-018 Channel status (identical both channels): bit0=0, bit2=1, bits24-27 fs (44.1k 0000, 48k 0100, 88.2k 0001, 96k 0101, 176.4k 0011, 192k 0111, bit24 first), bits32-35 word length (16-bit 0100, 24-bit 1101, bit32 first), others 0.
REQ-019 Frame counter SHALL wrap 191 -> 0 after right subframe; block_start_o pulses with each B.
REQ-020 bit_depth_i, sample_rate_i SHALL be sampled only at frame-0 left PREAMBLE entry.
REQ-021 enable_i low SHALL finish current right subframe, then IDLE; spdif_o holds last level; active_o low from IDLE entry.
REQ-022 spdif_o SHALL change only in the cycle after cell_en_i; latency cell_en_i -> spdif_o = 1 cycle.
REQ-023 BIT_DEPTH_32/DOP SHALL be treated as 24-bit.

Reset
REQ-024 Reset SHALL force IDLE, spdif_o=0, sample_ready_o=1, active_o=underrun_o=block_start_o=0, buffer empty, frame counter 0, line level 0; reset mid-frame aborts immediately.

Structure
REQ-025 Preamble patterns, channel-status fs/word-length codes, 192 block length SHALL live in the shared definitions package.
REQ-026 Channel-status bit lookup SHALL be a sub-module spdif_channel_status (frame index, rate, depth -> bit).

Verification
REQ-027 Reset, enable_i=1, cell_en_i every 4 clocks, no samples -> B preamble 11101000, 56 cells with V=1, underrun_o pulses each subframe.
REQ-028 Feed 24-bit 0x000001 left, 0xFFFFFF right -> left slot 4 =1 with P=1; right slots 4-27 =1, P=0; W preamble polarity follows line level.
REQ-029 Stream 400 frames at 48k/16-bit -> block_start_o every 192 frames; decoded C bits 24-27 = 0100, 32-35 = 0100.
REQ-030 sample_valid_i held high continuously -> no underrun; each sample consumed exactly once; ready drops one cycle after load.
REQ-031 enable_i dropped mid-left subframe -> right subframe completes, IDLE, spdif_o constant; assert reset_i mid-DATA -> spdif_o=0 next edge.
